// File: rtl/alu_result_collector.sv
// Pairs ALU header/result words into {status, result} entries and queues them for the host in a FWFT FIFO.
// Optional header parity checking is enabled by defining ALU_RESULT_PARITY_EN.
module alu_result_collector #(
  parameter int BUS_WIDTH = 16,
  parameter int RES_WIDTH = 12,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_WIDTH-1:0]       alu_data,
  input  logic                       alu_valid,
  input  logic                       alu_cmd,
  output logic [RES_WIDTH-1:0]       res_data,
  output logic [1:0]                 res_status,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]       res_count,
  output logic                       overflow,
  output logic                       proto_err,
`ifdef ALU_RESULT_PARITY_EN
  output logic                       parity_err,
`endif
  input  logic                       clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t               state, next_state;
  logic [1:0]           hdr_status;
  logic [RES_WIDTH-1:0] mem_data   [DEPTH];
  logic [1:0]           mem_status [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 orphan, dup_hdr, push_req, push, pop, full, empty, drop;
  logic [1:0]           push_status;
  logic                 unused_bus;

  // Header bits not otherwise consumed are folded here so none look dangling.
  assign unused_bus = ^alu_data;

  always_comb begin
    next_state = state;
    orphan     = 1'b0;
    dup_hdr    = 1'b0;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (alu_valid) begin
          if (alu_cmd) next_state = WAIT_DATA;
          else         orphan     = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (alu_valid) begin
          if (alu_cmd) begin
            dup_hdr = 1'b1;
          end else begin
            push_req   = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst)                         hdr_status <= 2'b00;
    else if (alu_valid && alu_cmd)   hdr_status <= alu_data[BUS_WIDTH-1 -: 2];
  end

`ifdef ALU_RESULT_PARITY_EN
  logic hdr_par, par_bad;

  always_ff @(posedge clk) begin
    if (rst)                         hdr_par <= 1'b0;
    else if (alu_valid && alu_cmd)   hdr_par <= alu_data[BUS_WIDTH-3];
  end

  assign par_bad     = hdr_par != (^alu_data[RES_WIDTH-1:0]);
  assign push_status = par_bad ? 2'b11 : hdr_status;

  always_ff @(posedge clk) begin
    if (rst)                         parity_err <= 1'b0;
    else if (push_req && par_bad)    parity_err <= 1'b1;
    else if (clr_flags)              parity_err <= 1'b0;
  end
`else
  assign push_status = hdr_status;
`endif

  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = wr_ptr == rd_ptr;
  assign full       = fifo_level == FULL_LEVEL;
  assign pop        = !empty && res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]]   <= alu_data[RES_WIDTH-1:0];
      mem_status[wr_ptr[AW-1:0]] <= push_status;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      res_count <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + (AW+1)'(1);
        res_count <= res_count + CNT_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (drop)                  overflow  <= 1'b1;
      else if (clr_flags)        overflow  <= 1'b0;
      if (orphan || dup_hdr)     proto_err <= 1'b1;
      else if (clr_flags)        proto_err <= 1'b0;
    end
  end

  assign res_valid  = !empty;
  assign res_data   = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign res_status = empty ? 2'b00 : mem_status[rd_ptr[AW-1:0]];

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Sits directly downstream of the ALU top level and consumes its 16-bit output stream (data_out/valid_out/cmd_out).
- Pairs each response header word with its following result word into a {status, result} entry.
- Buffers entries in a first-word-fall-through FIFO and presents them to the host over a ready/valid interface.
- Tracks accepted-result count and sticky overflow/protocol-error flags.

Parameters:
- BUS_WIDTH, 16, width of the ALU output bus.
- RES_WIDTH, 12, width of a result word; takes bus bits [RES_WIDTH-1:0].
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- CNT_WIDTH, 16, width of the accepted-result counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_data  in  BUS_WIDTH  ALU output word.
- alu_valid  in  1  alu_data valid this cycle; no backpressure toward the ALU.
- alu_cmd  in  1  1 = header word, 0 = result word.
- res_data  out  RES_WIDTH  FIFO head result.
- res_status  out  2  FIFO head status.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  host pops the head when res_valid & res_ready.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- res_count  out  CNT_WIDTH  results accepted into the FIFO.
- overflow  out  1  sticky; set when a complete result is dropped because the FIFO is full.
- proto_err  out  1  sticky; set on a header/result sequencing error.
- clr_flags  in  1  clears overflow and proto_err.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; FIFO is emptied.
  - res_valid=0, fifo_level=0, res_count=0, overflow=0, proto_err=0.
  - res_data and res_status read 0 while the FIFO is empty.
  - A reset mid-pair discards the latched header.
- Header format (alu_cmd=1): status = alu_data[15:14]; bits [13:0] are ignored unless the optional feature is enabled.
- Result format (alu_cmd=0): result = alu_data[RES_WIDTH-1:0]; upper bits are ignored.
- FSM states IDLE and WAIT_DATA:
  - IDLE, alu_valid & alu_cmd: latch status, go to WAIT_DATA.
  - IDLE, alu_valid & !alu_cmd: orphan result; drop the word, set proto_err, stay in IDLE.
  - WAIT_DATA, alu_valid & !alu_cmd: push {status, result}, go to IDLE.
  - WAIT_DATA, alu_valid & alu_cmd: set proto_err; the new header replaces the latched one; stay in WAIT_DATA.
  - alu_valid=0: hold state indefinitely; there is no timeout.
- Push/pop rules:
  - Latency: a result word accepted at edge N gives res_valid=1 with the head data visible after edge N.
  - fifo_level updates on the same edge as the push.
  - Pop occurs at an edge with res_valid & res_ready; the next entry is visible after that edge.
  - Push when full and no pop: entry is dropped, overflow set, res_count unchanged, FSM returns to IDLE.
  - Push and pop in the same cycle while full: both happen, nothing is dropped, level stays at DEPTH.
  - Push and pop in the same cycle at any other level: level unchanged.
  - Pop while empty: ignored, because res_ready is only honoured with res_valid.
- Counters and flags:
  - res_count increments by 1 per accepted push and wraps from 2^CNT_WIDTH-1 to 0.
  - If clr_flags and a flag-setting event occur in the same cycle, the set wins.
- Pointers: read and write pointers wrap modulo DEPTH; full/empty are derived from a one-bit-extended pointer or an occupancy counter.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- When defined:
  - Header bit [13] carries even parity of the following result word [RES_WIDTH-1:0].
  - On mismatch, the pushed entry's status is forced to 2'b11.
  - The extra output port parity_err (1 bit) is set sticky; it is cleared by clr_flags and by reset.
- When undefined: bit [13] is ignored, status passes through unchanged, and the parity_err port does not exist.

Test Plan:
- Header 0x4000 then result 0x0ABC with res_ready=0 -> res_valid=1, res_status=2'b01, res_data=0xABC, fifo_level=1, res_count=1.
- Result 0x0123 with no preceding header -> proto_err=1, fifo_level=0; clr_flags pulse -> proto_err=0.
- Header 0x8000, header 0xC000, result 0x0005 -> one entry with status 2'b11, data 0x005, proto_err=1.
- 9 pairs with res_ready=0 (DEPTH=8) -> fifo_level=8, overflow=1, res_count=8; 9th pair, full with res_ready=1 in the same cycle -> accepted, level stays 8, res_count=9.
- rst=1 asserted between a header and its result -> all outputs 0; a following lone result sets proto_err.
- With ALU_RESULT_PARITY_EN: header 0x0000 then result 0x0001 -> status 2'b11, parity_err=1; header 0x2000 then result 0x0001 -> status 2'b00, parity_err unchanged.
